parity_frame_tx: RTL
====================

// Module: parity_frame_tx
// PURPOSE
//  Serial framer downstream of the even-parity generator. Accepts a parallel
//  word on a valid/ready handshake and serialises it LSB-first as a frame:
//  start(0), DATA_WIDTH data bits, optional even-parity bit, STOP_BITS stop(1).
//  Feeds a UART-style line driver or pin; the parity bit comes from a parity instance.
// PARAMETERS
//  DATA_WIDTH    8  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clk cycles each line bit is held (>=1)
//  STOP_BITS     1  stop bits per frame (1 or 2)
//  PARITY_EN     1  1: insert even-parity bit after data; 0: omit it
// PORTS
//  clk    in   1           single clock, all logic on posedge
//  rst    in   1           synchronous, active-high reset
//  di     in   DATA_WIDTH  word to transmit, sampled on accept
//  valid  in   1           upstream has a word on di
//  ready  out  1           block can accept; transfer when valid && ready
//  tx     out  1           serial line, idle high
//  busy   out  1           frame in progress (any state but IDLE)
// BEHAVIOUR
//  - Reset (rst high at posedge): state=IDLE, tx=1, ready=1, busy=0, counters=0.
//    rst overrides everything, including mid-frame: tx returns to 1 the next cycle
//    and any partial frame is dropped.
//  - All outputs are registered; ready = (state==IDLE).
//  - Accept: at a posedge with valid && ready, latch di into shift register,
//    register parity(di) into par_q, go to START. Next cycle: tx=0, ready=0, busy=1.
//  - States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//  - Baud counter counts 0..CLKS_PER_BIT-1; every line bit holds exactly
//    CLKS_PER_BIT cycles; the state/bit advances when the counter wraps.
//  - DATA: tx = shreg[0]; shift right on each bit boundary; bit counter 0..DATA_WIDTH-1.
//  - PARITY: tx = par_q (XOR of latched word; even parity, total ones even).
//  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; then IDLE, ready=1.
//  - Frame length F = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles of
//    tx driven by the frame; minimum accept-to-accept spacing is F+1 cycles
//    (one IDLE cycle with tx=1 between back-to-back frames).
//  - valid while ready=0 is ignored; di changes mid-frame do not affect the
//    frame or its parity (parity is computed from di at accept, not from shreg).
//  - Counter widths: $clog2 of their max count, min 1 bit; no wrap beyond max.
//  - CLKS_PER_BIT=1 must work: no extra stall cycles anywhere.
// STRUCTURE
//  - Sub-module: parity #(.DATA_WIDTH(DATA_WIDTH)) on di; output registered at accept.
//  - State encoding (IDLE, START, DATA, PARITY, STOP) as localparams in a
//    shared serial-framing constants header, for reuse by the matching receiver/checker.
//  - No other sub-modules; FSM, baud counter, bit counter, shift register inline.
// TESTING (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, PARITY_EN=1 unless noted)
//  - Send 0xA5 -> tx after accept: 0, 1,0,1,0,0,1,0,1, par 0, stop 1; each bit held
//    4 cycles; ready high again after 44 cycles.
//  - Send 0x07 -> par bit 1; sampling mid-bit, the decoded word equals 0x07.
//  - valid held high with 0x01 then 0xFF -> two frames with exactly one idle cycle
//    (tx=1, ready=1) between them; no word lost or duplicated.
//  - Change di and pulse valid mid-frame -> frame unchanged, no second accept.
//  - Assert rst during DATA bit 3 -> next cycle tx=1, ready=1, busy=0; a
//    following 0x3C frame is correct.
//  - CLKS_PER_BIT=1, STOP_BITS=2, PARITY_EN=0, send 0x80 -> 11-cycle frame
//    0,0000000,1,1,1.

Source files
------------

// File: rtl/parity_frame_tx_pkg.sv
// Shared serial-framing constants.
//
// Holds the frame state encoding and a counter-width helper. The matching
// receiver/checker imports the same package so both ends agree on state
// numbering when states are compared or logged.
//
// Contents:
//   state_t    frame states IDLE, START, DATA, PARITY, STOP
//   cnt_width  register width needed to hold 0..n_values-1, minimum 1 bit
package parity_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // A counter that only ever holds 0..n_values-1 needs $clog2(n_values)
    // bits. A single-value counter still needs one physical bit.
    function automatic int cnt_width(input int n_values);
        return (n_values > 1) ? $clog2(n_values) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_tx_parity.sv
// Even-parity generator.
//
// par is the XOR of all bits of di. Appending par to di therefore gives a
// total count of ones that is even. This block is purely combinational; the
// framer registers its output when it accepts a word.
//
// Ports:
//   di   in   DATA_WIDTH  word to protect
//   par  out  1           even-parity bit for di
module parity #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] di,
    output logic                  par
);

    assign par = ^di;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter with an optional even-parity bit.
//
// The block accepts a word on a valid/ready handshake. It sends the word LSB
// first as: start(0), DATA_WIDTH data bits, an optional parity bit, then
// STOP_BITS stop bits(1). Each line bit is held for CLKS_PER_BIT clocks. All
// outputs are registered.
//
// Ports:
//   clk    in   1           clock, all logic on posedge
//   rst    in   1           synchronous active-high reset
//   di     in   DATA_WIDTH  word to send, sampled when valid && ready
//   valid  in   1           upstream offers a word on di
//   ready  out  1           high only in IDLE
//   tx     out  1           serial line, idles high
//   busy   out  1           a frame is in progress
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    // The bit counter indexes data bits in DATA and stop bits in STOP.
    localparam int BIT_W  = cnt_width((DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_q;
    logic                  par_di;
    logic                  bit_end;
    logic                  accept;

    // Parity is taken from di at accept time. Later changes on di and the
    // shifting of shreg cannot corrupt it.
    parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .di  (di),
        .par (par_di)
    );

    assign accept  = valid && ready;
    // With CLKS_PER_BIT == 1 the counter sits at 0, so every cycle is a bit
    // boundary and no stall cycles are added.
    assign bit_end = (baud_cnt == BAUD_LAST);

    // Data path: word and parity captured at accept. The register shifts
    // right at each boundary where the next line bit is loaded from shreg[0].
    // That happens when START ends and at each DATA boundary; a shift after
    // the last data bit is harmless.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= di;
            par_q <= par_di;
        end else if (bit_end && (state == ST_START || state == ST_DATA)) begin
            shreg <= shreg >> 1;
        end
    end

    // Control: FSM, baud counter, bit counter and registered outputs.
    // tx is always loaded together with the state change, so the line bit
    // and the state it belongs to start on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state == ST_IDLE) begin
            if (valid) begin
                state    <= ST_START;
                tx       <= 1'b0;
                ready    <= 1'b0;
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                tx    <= par_q;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                        end
                    end
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                    ST_STOP: begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= ST_IDLE;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        tx      <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
